imm_decode_stage: RTL

- Registered, parametrised immediate-generation stage between fetch and execute.
- Decodes all RV32I immediate formats (I, S, B, U, J, shift-amount), sign-extends each to XLEN bits, and classifies the instruction format.
- Flags unsupported opcodes and counts them.
- Uses a valid/ready handshake with a 2-entry skid buffer, so stalls never drop or duplicate an instruction.

---
 rtl/imm_decode_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered RV32I immediate decoder with a valid/ready
// handshake and a two-entry (main + skid) output buffer. Also counts illegal
// opcodes that leave the stage, saturating at the counter maximum.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  entry_t            dec;
  entry_t            main_q;
  entry_t            skid_q;
  logic              main_valid;
  logic              skid_valid;
  logic [CNT_W-1:0]  cnt;
  logic              in_xfer;
  logic              out_xfer;

  // in_ready depends only on the skid register, never on out_ready.
  assign in_ready    = !skid_valid;
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = main_valid && out_ready;

  assign out_valid   = main_valid;
  assign out_inst    = main_q.inst;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign illegal_cnt = cnt;

  // Decode the incoming word into format, sign-extended immediate and legality.
  always_comb begin
    dec.inst    = in_inst;
    dec.pc      = in_pc;
    dec.imm     = '0;
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;
    case (in_inst[6:0])
      7'b0010011: begin
        if (in_inst[13:12] == 2'b01) begin
          dec.fmt      = FMT_SHAMT;
          dec.imm[4:0] = in_inst[24:20];
          if (XLEN == 64) dec.imm[5] = in_inst[25];
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(in_inst[31:20]));
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_inst[31:20]));
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                 in_inst[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                 in_inst[30:21], 1'b0}));
      end
      7'b0110011, 7'b0001111: begin
        dec.fmt = FMT_R;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Main/skid buffer: skid only fills when main is stalled, and drains into main first.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_q <= dec;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
    end
  end

  // Saturating count of illegal entries leaving the stage; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_xfer && main_q.illegal && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
